dual_issue_queue: RTL and testbench

- Instruction buffer between fetch and the dual-issue hazard/steer stage.
- Fetch pushes up to 2 instructions per cycle. The queue presents the two oldest entries as an instruction pair, with pc and a queue-assigned instruction id.
- The hazard stage returns how many of the pair it consumed: 0 on a load stall, 1 on a split stall, 2 otherwise. Unconsumed entries are re-presented next cycle.
- Empty output slots carry instruction 0, pc 0 and id 0, which downstream treats as a NOP/bubble.

---
 rtl/dual_issue_queue.sv | 132 +++++++++++++
 tb/tb_dual_issue_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_queue.sv
// Dual-issue instruction queue: fetch pushes 0-2 per cycle, the hazard stage consumes 0-2 of the oldest pair.
// Latency: 1 cycle push-to-output; 0 cycles from empty when DUAL_ISSUE_QUEUE_BYPASS_EN is defined.
// Backpressure: push_ready drops when fewer than 2 slots are free; a rejected push is dropped whole.
module dual_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [1:0]              push_count,
    input  logic [INST_WIDTH-1:0]   push_inst0,
    input  logic [INST_WIDTH-1:0]   push_inst1,
    input  logic [ADDR_WIDTH-1:0]   push_pc0,
    input  logic [ADDR_WIDTH-1:0]   push_pc1,
    output logic                    push_ready,
    input  logic [1:0]              pop_count,
    output logic [INST_WIDTH-1:0]   instruction0_out,
    output logic [INST_WIDTH-1:0]   instruction1_out,
    output logic [ADDR_WIDTH-1:0]   pc0_out,
    output logic [ADDR_WIDTH-1:0]   pc1_out,
    output logic [ID_WIDTH-1:0]     id0_out,
    output logic [ID_WIDTH-1:0]     id1_out,
    output logic [1:0]              valid_out,
    output logic [$clog2(DEPTH):0]  count_out
);
    localparam int PW = $clog2(DEPTH);

    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [ID_WIDTH-1:0]   id_mem   [DEPTH];

    logic [PW-1:0]       rd_ptr, wr_ptr, rd_ptr1;
    logic [PW:0]         count, avail, pop_eff;
    logic [ID_WIDTH-1:0] next_id, id_b;
    logic [1:0]          push_n, pop_req;

    // Id 0 is reserved for bubbles, so the counter skips it on wrap.
    function automatic logic [ID_WIDTH-1:0] id_inc(input logic [ID_WIDTH-1:0] v);
        return (v == '1) ? ID_WIDTH'(1) : v + ID_WIDTH'(1);
    endfunction

    assign push_ready = (count <= (PW+1)'(DEPTH - 2));
    assign push_n     = !push_ready ? 2'd0 : (push_count == 2'd3) ? 2'd2 : push_count;
    assign pop_req    = (pop_count == 2'd3) ? 2'd2 : pop_count;
    assign id_b       = id_inc(next_id);
    assign rd_ptr1    = rd_ptr + PW'(1);
    assign count_out  = count;

`ifdef DUAL_ISSUE_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass = (count == '0) && !flush && (push_n != 2'd0);
    assign avail  = bypass ? (PW+1)'(push_n) : count;
`else
    assign avail  = count;
`endif

    assign pop_eff = ((PW+1)'(pop_req) > avail) ? avail : (PW+1)'(pop_req);

    always_comb begin
        instruction0_out = '0;
        instruction1_out = '0;
        pc0_out          = '0;
        pc1_out          = '0;
        id0_out          = '0;
        id1_out          = '0;
        valid_out        = '0;
        if (count != '0) begin
            instruction0_out = inst_mem[rd_ptr];
            pc0_out          = pc_mem[rd_ptr];
            id0_out          = id_mem[rd_ptr];
            valid_out[0]     = 1'b1;
        end
        if (count >= (PW+1)'(2)) begin
            instruction1_out = inst_mem[rd_ptr1];
            pc1_out          = pc_mem[rd_ptr1];
            id1_out          = id_mem[rd_ptr1];
            valid_out[1]     = 1'b1;
        end
`ifdef DUAL_ISSUE_QUEUE_BYPASS_EN
        if (bypass) begin
            instruction0_out = push_inst0;
            pc0_out          = push_pc0;
            id0_out          = next_id;
            valid_out[0]     = 1'b1;
            if (push_n == 2'd2) begin
                instruction1_out = push_inst1;
                pc1_out          = push_pc1;
                id1_out          = id_b;
                valid_out[1]     = 1'b1;
            end
        end
`endif
    end

    // Bypassed entries are written like any push; rd_ptr then skips the ones consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            next_id <= ID_WIDTH'(1);
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + pop_eff[PW-1:0];
            count  <= count + (PW+1)'(push_n) - pop_eff;
            if (push_n == 2'd1)
                next_id <= id_b;
            else if (push_n == 2'd2)
                next_id <= id_inc(id_b);
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && push_n != 2'd0) begin
            inst_mem[wr_ptr] <= push_inst0;
            pc_mem[wr_ptr]   <= push_pc0;
            id_mem[wr_ptr]   <= next_id;
        end
        if (!flush && push_n == 2'd2) begin
            inst_mem[wr_ptr + PW'(1)] <= push_inst1;
            pc_mem[wr_ptr + PW'(1)]   <= push_pc1;
            id_mem[wr_ptr + PW'(1)]   <= id_b;
        end
    end
endmodule

// File: tb/tb_dual_issue_queue.sv
// Bench for dual_issue_queue: vector table, directed corner sequences and a random run
// checked against a queue-based reference model.
module tb_dual_issue_queue;
    localparam int DEPTH = 8;
    localparam int IW = 32;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset, flush;
    logic [1:0]    push_count, pop_count;
    logic [IW-1:0] push_inst0, push_inst1, instruction0_out, instruction1_out;
    logic [AW-1:0] push_pc0, push_pc1, pc0_out, pc1_out;
    logic [DW-1:0] id0_out, id1_out;
    logic          push_ready;
    logic [1:0]    valid_out;
    logic [CW-1:0] count_out;

    always #5 clk = ~clk;

    dual_issue_queue #(.DEPTH(DEPTH), .INST_WIDTH(IW), .ADDR_WIDTH(AW), .ID_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .push_count(push_count), .push_inst0(push_inst0), .push_inst1(push_inst1),
        .push_pc0(push_pc0), .push_pc1(push_pc1), .push_ready(push_ready),
        .pop_count(pop_count),
        .instruction0_out(instruction0_out), .instruction1_out(instruction1_out),
        .pc0_out(pc0_out), .pc1_out(pc1_out), .id0_out(id0_out), .id1_out(id1_out),
        .valid_out(valid_out), .count_out(count_out)
    );

    typedef struct {
        logic [IW-1:0] inst;
        logic [AW-1:0] pc;
        int            id;
    } ent_t;

    ent_t m_q[$];
    int   m_nid = 1;
    int   total = 0;
    int   bad   = 0;

    function automatic int id_next(input int n);
        return (n == (2**DW) - 1) ? 1 : n + 1;
    endfunction

    function automatic ent_t mk(input logic [IW-1:0] i, input logic [AW-1:0] p, input int id);
        ent_t e;
        e.inst = i; e.pc = p; e.id = id;
        return e;
    endfunction

    function automatic logic [63:0] pk(input ent_t e);
        return {8'h00, e.inst, e.pc, DW'(e.id)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        ent_t vis[$];
        ent_t z;
        int   sz;
        z = mk('0, '0, 0);
        vis = m_q;
`ifdef DUAL_ISSUE_QUEUE_BYPASS_EN
        begin
            int np;
            np = (push_count == 2'd3) ? 2 : int'(push_count);
            if (m_q.size() == 0 && !flush && np > 0) begin
                vis = {};
                vis.push_back(mk(push_inst0, push_pc0, m_nid));
                if (np == 2) vis.push_back(mk(push_inst1, push_pc1, id_next(m_nid)));
            end
        end
`endif
        sz = vis.size();
        chk("m_ready", 64'(push_ready), 64'(m_q.size() <= DEPTH - 2));
        chk("m_count", 64'(count_out), 64'(m_q.size()));
        chk("m_valid", 64'(valid_out), {62'd0, sz >= 2, sz >= 1});
        chk("m_slot0", {8'h00, instruction0_out, pc0_out, id0_out}, pk(sz >= 1 ? vis[0] : z));
        chk("m_slot1", {8'h00, instruction1_out, pc1_out, id1_out}, pk(sz >= 2 ? vis[1] : z));
    endtask

    task automatic model_update();
        int acc, avail, pops;
        if (flush) begin
            m_q.delete();
        end else begin
            acc   = (m_q.size() <= DEPTH - 2) ? ((push_count == 2'd3) ? 2 : int'(push_count)) : 0;
            avail = m_q.size();
`ifdef DUAL_ISSUE_QUEUE_BYPASS_EN
            if (avail == 0) avail = acc;
`endif
            pops = (pop_count == 2'd3) ? 2 : int'(pop_count);
            if (pops > avail) pops = avail;
            if (acc >= 1) begin m_q.push_back(mk(push_inst0, push_pc0, m_nid)); m_nid = id_next(m_nid); end
            if (acc == 2) begin m_q.push_back(mk(push_inst1, push_pc1, m_nid)); m_nid = id_next(m_nid); end
            repeat (pops) void'(m_q.pop_front());
        end
    endtask

    task automatic step(input logic fl, input logic [1:0] pn, input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                        input logic [AW-1:0] p0, input logic [AW-1:0] p1, input logic [1:0] pp);
        flush = fl; push_count = pn; push_inst0 = i0; push_inst1 = i1;
        push_pc0 = p0; push_pc1 = p1; pop_count = pp;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    typedef struct {
        logic          fl;
        logic [1:0]    pn;
        logic [IW-1:0] i0, i1;
        logic [AW-1:0] p0, p1;
        logic [1:0]    pp;
        logic [IW-1:0] e_i0, e_i1;
        logic [AW-1:0] e_p0, e_p1;
        logic [DW-1:0] e_id0, e_id1;
        logic [1:0]    e_v;
        logic [CW-1:0] e_cnt;
        logic          e_rdy;
    } vec_t;

    vec_t vt[6];
    int   saved_nid;
    int   guard;

    initial begin
        reset = 1'b0; flush = 1'b0; push_count = '0; pop_count = '0;
        push_inst0 = '0; push_inst1 = '0; push_pc0 = '0; push_pc1 = '0;
        #1;
        chk("rst_ready", 64'(push_ready), 64'd1);
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_slots", {instruction0_out, instruction1_out}, 64'd0);
        chk("rst_pcid", {16'h0, pc0_out, pc1_out, id0_out, id1_out}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

`ifndef DUAL_ISSUE_QUEUE_BYPASS_EN
        // Each row: inputs applied this cycle, outputs expected in this same cycle.
        vt[0] = '{1'b0, 2'd2, 32'h11, 32'h22, 16'd4, 16'd8, 2'd0, 32'h0,  32'h0,  16'd0,  16'd0,  8'd0, 8'd0, 2'b00, 4'd0, 1'b1};
        vt[1] = '{1'b0, 2'd1, 32'h33, 32'h0,  16'd12, 16'd0, 2'd0, 32'h11, 32'h22, 16'd4,  16'd8,  8'd1, 8'd2, 2'b11, 4'd2, 1'b1};
        vt[2] = '{1'b0, 2'd0, 32'h0,  32'h0,  16'd0, 16'd0, 2'd1, 32'h11, 32'h22, 16'd4,  16'd8,  8'd1, 8'd2, 2'b11, 4'd3, 1'b1};
        vt[3] = '{1'b0, 2'd0, 32'h0,  32'h0,  16'd0, 16'd0, 2'd1, 32'h22, 32'h33, 16'd8,  16'd12, 8'd2, 8'd3, 2'b11, 4'd2, 1'b1};
        vt[4] = '{1'b0, 2'd0, 32'h0,  32'h0,  16'd0, 16'd0, 2'd3, 32'h33, 32'h0,  16'd12, 16'd0,  8'd3, 8'd0, 2'b01, 4'd1, 1'b1};
        vt[5] = '{1'b0, 2'd0, 32'h0,  32'h0,  16'd0, 16'd0, 2'd0, 32'h0,  32'h0,  16'd0,  16'd0,  8'd0, 8'd0, 2'b00, 4'd0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step(vt[i].fl, vt[i].pn, vt[i].i0, vt[i].i1, vt[i].p0, vt[i].p1, vt[i].pp);
            chk($sformatf("vec%0d_inst", i), {instruction0_out, instruction1_out}, {vt[i].e_i0, vt[i].e_i1});
            chk($sformatf("vec%0d_pcid", i), {16'h0, pc0_out, pc1_out, id0_out, id1_out},
                {16'h0, vt[i].e_p0, vt[i].e_p1, vt[i].e_id0, vt[i].e_id1});
            chk($sformatf("vec%0d_vcr", i), {57'd0, valid_out, count_out, push_ready},
                {57'd0, vt[i].e_v, vt[i].e_cnt, vt[i].e_rdy});
            tick();
        end
`endif

        // Fill with 2-wide pushes: ready must drop at 8 and stay low during a pop-2 cycle.
        step(1, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            step(0, 2, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i), 16'(i), 16'(i), 0); tick();
        end
        saved_nid = m_nid;
        step(0, 2, 32'hDEAD, 32'hBEEF, 0, 0, 0);
        chk("full8_ready", 64'(push_ready), 64'd0);
        chk("full8_count", 64'(count_out), 64'd8);
        tick();
        step(0, 2, 32'hDEAD, 32'hBEEF, 0, 0, 2);
        chk("full8_pop_ready", 64'(push_ready), 64'd0);
        tick();
        step(0, 1, 32'h200, 0, 16'h20, 0, 0);
        chk("restore_ready", 64'(push_ready), 64'd1);
        chk("restore_count", 64'(count_out), 64'd6);
        tick();
        chk("full_id_hold", 64'(m_q[m_q.size()-1].id), 64'(saved_nid));

        // Occupancy 7 also blocks pushes.
        step(1, 0, 0, 0, 0, 0, 0); tick();
        step(0, 1, 32'h300, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            step(0, 2, 32'h310 + 32'(i), 32'h320 + 32'(i), 0, 0, 0); tick();
        end
        step(0, 2, 32'h3FF, 32'h3FE, 0, 0, 0);
        chk("full7_ready", 64'(push_ready), 64'd0);
        chk("full7_count", 64'(count_out), 64'd7);
        tick();

        // Flush with 5 queued entries and a same-cycle push.
        step(1, 0, 0, 0, 0, 0, 0); tick();
        step(0, 2, 32'h401, 32'h402, 1, 2, 0); tick();
        step(0, 2, 32'h403, 32'h404, 3, 4, 0); tick();
        step(0, 1, 32'h405, 0, 5, 0, 0); tick();
        saved_nid = m_nid;
        step(1, 2, 32'h4AA, 32'h4BB, 9, 9, 0); tick();
        step(0, 1, 32'h406, 0, 6, 0, 0);
`ifndef DUAL_ISSUE_QUEUE_BYPASS_EN
        chk("flush_count", 64'(count_out), 64'd0);
        chk("flush_valid", 64'(valid_out), 64'd0);
        chk("flush_zero", {instruction0_out, pc0_out, id0_out, 8'h0}, 64'd0);
`endif
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("flush_id_cont", 64'(id0_out), 64'(saved_nid));
        tick();

        // Drive next_id to 254 then push three to see the wrap skip id 0.
        step(1, 0, 0, 0, 0, 0, 0); tick();
        guard = 0;
        while (m_nid != 254 && guard < 600) begin
            step(0, 1, 32'h500 + 32'(guard), 0, 16'(guard), 0, 2); tick();
            guard++;
        end
        chk("wrap_reach", 64'(m_nid), 64'd254);
        step(1, 0, 0, 0, 0, 0, 0); tick();
        step(0, 2, 32'h601, 32'h602, 1, 2, 0); tick();
        step(0, 1, 32'h603, 0, 3, 0, 0); tick();
        step(0, 0, 0, 0, 0, 0, 2);
        chk("wrap_id0", 64'(id0_out), 64'd254);
        chk("wrap_id1", 64'(id1_out), 64'd255);
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_id_skip0", 64'(id0_out), 64'd1);
        tick();

`ifdef DUAL_ISSUE_QUEUE_BYPASS_EN
        step(1, 0, 0, 0, 0, 0, 0); tick();
        step(0, 2, 32'hA1, 32'hA2, 16'h10, 16'h14, 1);
        chk("byp_same_inst", {instruction0_out, instruction1_out}, {32'hA1, 32'hA2});
        chk("byp_same_valid", 64'(valid_out), 64'd3);
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        chk("byp_held_inst", 64'(instruction0_out), 64'hA2);
        chk("byp_held_count", 64'(count_out), 64'd1);
        tick();
`endif

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
                 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
